// File: rtl/para2seri_if.sv
// ---------------------------------------------------------------------------
// para2seri_if
//   Handshake bundle between a pixel-word producer/serial consumer and the
//   para2seri converter.
//
//   WIDTH      bits per parallel word (must match the converter's WIDTH)
//   iSTART     start strobe, sampled by the converter only while idle
//   iDATA      parallel word, captured on the accepted start edge
//   iREADY     downstream accepts oPIXEL this cycle
//   oPIXEL     current serial bit
//   oVALID     oPIXEL is valid
//   oBUSY      converter is shifting a word out
//   oFinished  one-cycle pulse after the last bit has transferred
//
//   master : the side driving the word and ready (producer/sink/testbench)
//   slave  : the converter itself
// ---------------------------------------------------------------------------
interface para2seri_if #(
    parameter int WIDTH = 640
);
    logic             iSTART;
    logic [WIDTH-1:0] iDATA;
    logic             iREADY;
    logic             oPIXEL;
    logic             oVALID;
    logic             oBUSY;
    logic             oFinished;

    modport master (
        output iSTART, iDATA, iREADY,
        input  oPIXEL, oVALID, oBUSY, oFinished
    );

    modport slave (
        input  iSTART, iDATA, iREADY,
        output oPIXEL, oVALID, oBUSY, oFinished
    );
endinterface

// File: rtl/para2seri.sv
// ---------------------------------------------------------------------------
// para2seri
//   Parallel-to-serial converter for the pixel path. Latches a WIDTH-bit word
//   on iSTART (while idle) and shifts it out one bit per accepted transfer
//   (oVALID && iREADY). A one-cycle oFinished pulse follows the last bit.
//
//   Ports:
//     iCLK    sole clock, rising edge
//     iRST_n  asynchronous active-low reset
//     bus     para2seri_if.slave (iSTART, iDATA, iREADY / oPIXEL, oVALID,
//             oBUSY, oFinished)
//
//   Parameters:
//     WIDTH   bits per word, 2..4096 (default 640, one pixel line)
//
//   Build option:
//     PARA2SERI_LSB_FIRST_EN  when defined, iDATA[0] is sent first and the
//                             register shifts right; otherwise MSB first.
//
//   Every output is a register bit; nothing combinational reaches the pins.
// ---------------------------------------------------------------------------
module para2seri #(
    parameter int WIDTH = 640
) (
    input logic       iCLK,
    input logic       iRST_n,
    para2seri_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] shiftReg;
    logic [CNT_W-1:0] bitCnt;
    logic             valid;
    logic             busy;
    logic             finished;

    logic             xfer;
    logic [WIDTH-1:0] shiftNext;

    assign xfer = valid & bus.iREADY;

`ifdef PARA2SERI_LSB_FIRST_EN
    assign shiftNext  = {1'b0, shiftReg[WIDTH-1:1]};
    assign bus.oPIXEL = shiftReg[0];
`else
    assign shiftNext  = {shiftReg[WIDTH-2:0], 1'b0};
    assign bus.oPIXEL = shiftReg[WIDTH-1];
`endif

    assign bus.oVALID    = valid;
    assign bus.oBUSY     = busy;
    assign bus.oFinished = finished;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The finished cycle is itself an IDLE cycle, so a start
                    // here gives back-to-back words with a single gap cycle.
                    finished <= 1'b0;
                    if (bus.iSTART) begin
                        shiftReg <= bus.iDATA;
                        bitCnt   <= '0;
                        state    <= RUN;
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        // Shifting on the last bit too leaves the register
                        // zeroed, so oPIXEL rests at 0 between words.
                        shiftReg <= shiftNext;
                        if (bitCnt == LAST_BIT) begin
                            state    <= IDLE;
                            valid    <= 1'b0;
                            busy     <= 1'b0;
                            finished <= 1'b1;
                            bitCnt   <= '0;
                        end else begin
                            bitCnt <= bitCnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
